spi_fifo_master: RTL and testbench

Command-queued SPI write master: buffers 32-bit command words in an internal FIFO and serializes each as one 24-bit frame (8-bit address followed by 16-bit data) on a 3-wire bus (SEN active-low, SCLK, SDATA). It sits between a register-level host, which pushes words and pulses `start`, and an external serially-programmed device. Once started, it drains the whole FIFO back-to-back and then returns idle.

---
 rtl/spi_fifo_master_pkg.sv | 22 ++
 rtl/spi_cmd_fifo.sv | 60 ++++++
 rtl/spi_fifo_master.sv | 178 +++++++++++++++++
 tb/tb_spi_fifo_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_fifo_master_pkg.sv
// spi_fifo_master_pkg: shared constants, FSM state encoding and a small helper
// for the command-queued SPI write master.
package spi_fifo_master_pkg;

    localparam int ADDR_BITS_DEFAULT  = 8;
    localparam int DATA_BITS_DEFAULT  = 16;
    localparam int FIFO_DEPTH_DEFAULT = 8;
    localparam int FRAME_BITS         = ADDR_BITS_DEFAULT + DATA_BITS_DEFAULT;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    // A programmed ratio of zero would stall the divider, so it is promoted to one.
    function automatic logic [7:0] half_period_of(input logic [7:0] ratio);
        return (ratio == 8'd0) ? 8'd1 : ratio;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: show-ahead synchronous FIFO holding queued SPI command words.
// A push while full is accepted only when a pop happens in the same cycle.
module spi_cmd_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_fifo_master.sv
// spi_fifo_master: queues 32-bit command words and sends each as a 24-bit
// address+data frame on a 3-wire SPI bus (SEN low-active, SCLK, SDATA).
// Optional build macro SPI_LSB_FIRST_EN sends each field LSB first
// (address still before data); by default both fields go MSB first.
module spi_fifo_master
    import spi_fifo_master_pkg::*;
#(
    parameter int ADDR_BITS  = ADDR_BITS_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  clk_ratio,
    input  logic        fifo_wren,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        data_full,
    output logic        data_empty,
    output logic        SEN,
    output logic        SCLK,
    output logic        SDATA
);

    localparam int FRAME_LEN = ADDR_BITS + DATA_BITS;
    localparam int BIT_CNT_W = $clog2(FRAME_LEN);
    localparam int COUNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_LEN - 1);

    state_t                 state;
    state_t                 next_state;
    logic                   fifo_pop;
    logic [FRAME_LEN-1:0]   head_word;
    logic [FRAME_LEN-1:0]   frame_word;
    logic [COUNT_W-1:0]     unused_fifo_count;
    logic                   unused_upper_bits;
    logic [FRAME_LEN-1:0]   shift_reg;
    logic [7:0]             half_period;
    logic [7:0]             phase_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   phase_end;
    logic                   last_bit;

    // Command words carry no meaning above the frame, so those bits are dropped here.
    assign unused_upper_bits = ^data_in[31:FRAME_LEN];

    spi_cmd_fifo #(
        .WIDTH (FRAME_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_wren),
        .pop   (fifo_pop),
        .wdata (data_in[FRAME_LEN-1:0]),
        .rdata (head_word),
        .full  (data_full),
        .empty (data_empty),
        .count (unused_fifo_count)
    );

    assign phase_end = (phase_cnt == (half_period - 8'd1));
    assign last_bit  = (bit_cnt == LAST_BIT);

    // Arrange the head word as address-then-data, reversing each field for LSB-first builds.
    always_comb begin
        frame_word = '0;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < ADDR_BITS; i++) begin
            frame_word[DATA_BITS + i] = head_word[ADDR_BITS - 1 - i];
        end
        for (int i = 0; i < DATA_BITS; i++) begin
            frame_word[i] = head_word[ADDR_BITS + DATA_BITS - 1 - i];
        end
`else
        frame_word = {head_word[ADDR_BITS-1:0], head_word[FRAME_LEN-1:ADDR_BITS]};
`endif
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the FIFO pop strobe issued while loading a frame.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !data_empty) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                fifo_pop   = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                if (phase_end && SCLK && last_bit) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    next_state = data_empty ? IDLE : LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Serializer, SCLK divider and registered bus outputs; busy falls one cycle after IDLE is reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            half_period <= 8'd1;
            phase_cnt   <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            SEN         <= 1'b1;
            SCLK        <= 1'b0;
            SDATA       <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state == IDLE) ? (start && !data_empty) : 1'b1;
            case (state)
                LOAD: begin
                    SDATA       <= frame_word[FRAME_LEN-1];
                    shift_reg   <= {frame_word[FRAME_LEN-2:0], 1'b0};
                    half_period <= half_period_of(clk_ratio);
                    phase_cnt   <= '0;
                    bit_cnt     <= '0;
                    SEN         <= 1'b0;
                    SCLK        <= 1'b0;
                end
                SHIFT: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                        end else if (last_bit) begin
                            SEN   <= 1'b1;
                            SCLK  <= 1'b0;
                            SDATA <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            SCLK      <= 1'b0;
                            SDATA     <= shift_reg[FRAME_LEN-1];
                            shift_reg <= {shift_reg[FRAME_LEN-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                default: begin
                    phase_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_master.sv
// tb_spi_fifo_master: directed, table-driven bench for spi_fifo_master.
// Honours SPI_LSB_FIRST_EN to select the expected bit order.
module tb_spi_fifo_master;
    import spi_fifo_master_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  clk_ratio;
    logic        fifo_wren;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        data_full;
    logic        data_empty;
    logic        SEN;
    logic        SCLK;
    logic        SDATA;

    int compare_count = 0;
    int fail_count    = 0;
    int cycle_count   = 0;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  ratio;
        logic [23:0] exp_msb;
        logic [23:0] exp_lsb;
        int          exp_len;
        int          exp_lag;
    } vec_t;

    vec_t vectors [5];

    spi_fifo_master dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .clk_ratio  (clk_ratio),
        .fifo_wren  (fifo_wren),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .data_full  (data_full),
        .data_empty (data_empty),
        .SEN        (SEN),
        .SCLK       (SCLK),
        .SDATA      (SDATA)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_count <= cycle_count + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [23:0] expFrame(input logic [31:0] word);
        logic [23:0] f;
        f = '0;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) f[16 + i] = word[7 - i];
        for (int i = 0; i < 16; i++) f[i] = word[23 - i];
`else
        f = {word[7:0], word[23:8]};
`endif
        return f;
    endfunction

    task automatic pushWord(input logic [31:0] word);
        fifo_wren = 1'b1;
        data_in   = word;
        step();
        fifo_wren = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic [7:0] ratio);
        clk_ratio = ratio;
        pushWord(word);
        pulseStart();
    endtask

    task automatic captureFrame(input int push_at, input logic [31:0] push_word,
                                output logic [23:0] bits, output int low_cycles,
                                output int rises, output int done_low,
                                output logic done_end, output int fall_cycle,
                                output bit timed_out);
        int guard;
        logic prev_sclk;
        bits = '0; low_cycles = 0; rises = 0; done_low = 0;
        done_end = 1'b0; fall_cycle = 0; timed_out = 1'b0; guard = 0;
        while (SEN !== 1'b0 && guard < 100) begin
            step();
            guard++;
        end
        if (SEN !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        fall_cycle = cycle_count;
        prev_sclk  = 1'b0;
        while (SEN === 1'b0 && low_cycles < 20000) begin
            fifo_wren = (low_cycles == push_at);
            data_in   = push_word;
            if (done === 1'b1) done_low++;
            if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
                bits = {bits[22:0], SDATA};
                rises++;
            end
            prev_sclk = SCLK;
            low_cycles++;
            step();
        end
        fifo_wren = 1'b0;
        if (SEN !== 1'b1) timed_out = 1'b1;
        else done_end = done;
    endtask

    task automatic waitBusyLow(output int lag, output bit timed_out);
        lag = 0;
        while (busy === 1'b1 && lag < 2000) begin
            step();
            lag++;
        end
        timed_out = (busy !== 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [23:0] bits;
        logic [23:0] exp_bits;
        logic        done_end;
        int          low_cycles, rises, done_low, fall_cycle, prev_fall, lag, guard;
        bit          timed_out, sen_seen, busy_seen;
        logic [31:0] fifo_words [9];

        vectors[0] = '{32'h00ABCD5A, 8'd2,   24'h5AABCD, 24'h5AB3D5, 96,    3};
        vectors[1] = '{32'h00000180, 8'd0,   24'h800001, 24'h018000, 48,    2};
        vectors[2] = '{32'hFF8001C3, 8'd1,   24'hC38001, 24'hC38001, 48,    2};
        vectors[3] = '{32'h0012340F, 8'd3,   24'h0F1234, 24'hF02C48, 144,   4};
        vectors[4] = '{32'h0000FFA5, 8'd255, 24'hA500FF, 24'hA5FF00, 12240, 256};

        reset = 1'b1; start = 1'b0; clk_ratio = 8'd1; fifo_wren = 1'b0; data_in = '0;
        step();
        step();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sen", {31'd0, SEN}, 32'd1);
        checkOutput("reset_sclk", {31'd0, SCLK}, 32'd0);
        checkOutput("reset_sdata", {31'd0, SDATA}, 32'd0);
        checkOutput("reset_empty", {31'd0, data_empty}, 32'd1);
        checkOutput("reset_full", {31'd0, data_full}, 32'd0);
        reset = 1'b0;
        step();

        // Table-driven single-word frames across several divider settings.
        for (int v = 0; v < 5; v++) begin
`ifdef SPI_LSB_FIRST_EN
            exp_bits = vectors[v].exp_lsb;
`else
            exp_bits = vectors[v].exp_msb;
`endif
            applyStimulus(vectors[v].word, vectors[v].ratio);
            checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
            captureFrame(-1, '0, bits, low_cycles, rises, done_low, done_end, fall_cycle, timed_out);
            checkOutput("frame_timeout", {31'd0, timed_out}, 32'd0);
            checkOutput("frame_bits", {8'd0, bits}, {8'd0, exp_bits});
            checkOutput("sen_low_cycles", low_cycles, vectors[v].exp_len);
            checkOutput("sclk_rises", rises, FRAME_BITS);
            checkOutput("done_during_frame", done_low, 0);
            checkOutput("done_at_end", {31'd0, done_end}, 32'd1);
            waitBusyLow(lag, timed_out);
            checkOutput("busy_timeout", {31'd0, timed_out}, 32'd0);
            checkOutput("busy_lag", lag, vectors[v].exp_lag);
            step();
        end

        // Start with an empty FIFO must be ignored.
        sen_seen = 1'b0; busy_seen = 1'b0;
        pulseStart();
        for (int i = 0; i < 20; i++) begin
            if (SEN !== 1'b1) sen_seen = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
            step();
        end
        checkOutput("empty_start_sen", {31'd0, sen_seen}, 32'd0);
        checkOutput("empty_start_busy", {31'd0, busy_seen}, 32'd0);

        // Full FIFO: nine pushes, only eight kept, drained in order.
        doReset();
        clk_ratio = 8'd1;
        for (int i = 0; i < 9; i++) begin
            fifo_words[i] = {8'h00, 16'h1000 + 16'(i * 16'h0111), 8'h20 + 8'(i)};
        end
        fifo_words[8] = 32'h00DEAD99;
        for (int i = 0; i < 7; i++) pushWord(fifo_words[i]);
        checkOutput("full_after_7", {31'd0, data_full}, 32'd0);
        pushWord(fifo_words[7]);
        checkOutput("full_after_8", {31'd0, data_full}, 32'd1);
        pushWord(fifo_words[8]);
        checkOutput("full_after_9", {31'd0, data_full}, 32'd1);
        pulseStart();
        prev_fall = 0;
        for (int i = 0; i < 8; i++) begin
            captureFrame(-1, '0, bits, low_cycles, rises, done_low, done_end, fall_cycle, timed_out);
            checkOutput("drain_timeout", {31'd0, timed_out}, 32'd0);
            checkOutput("drain_frame", {8'd0, bits}, {8'd0, expFrame(fifo_words[i])});
            if (i > 0) checkOutput("frame_period", fall_cycle - prev_fall, 50);
            prev_fall = fall_cycle;
        end
        waitBusyLow(lag, timed_out);
        checkOutput("drain_busy_timeout", {31'd0, timed_out}, 32'd0);
        checkOutput("drain_empty", {31'd0, data_empty}, 32'd1);
        sen_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (SEN !== 1'b1) sen_seen = 1'b1;
            step();
        end
        checkOutput("no_ninth_frame", {31'd0, sen_seen}, 32'd0);

        // Word pushed mid-drain goes out without another start.
        clk_ratio = 8'd1;
        applyStimulus(32'h0011113C, 8'd1);
        captureFrame(10, 32'h002222C5, bits, low_cycles, rises, done_low, done_end, fall_cycle, timed_out);
        checkOutput("drain_push_first", {8'd0, bits}, {8'd0, expFrame(32'h0011113C)});
        captureFrame(-1, '0, bits, low_cycles, rises, done_low, done_end, fall_cycle, timed_out);
        checkOutput("drain_push_timeout", {31'd0, timed_out}, 32'd0);
        checkOutput("drain_push_second", {8'd0, bits}, {8'd0, expFrame(32'h002222C5)});
        waitBusyLow(lag, timed_out);
        checkOutput("drain_push_busy", {31'd0, timed_out}, 32'd0);

        // Reset during bit 10 aborts at once and drops the queue.
        clk_ratio = 8'd1;
        pushWord(32'h00ABCD5A);
        pushWord(32'h00123456);
        pulseStart();
        guard = 0; rises = 0;
        while (rises < 10 && guard < 200) begin
            step();
            if (SEN === 1'b0 && SCLK === 1'b1) rises++;
            guard++;
        end
        checkOutput("reset_wait_timeout", rises, 10);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_sen", {31'd0, SEN}, 32'd1);
        checkOutput("abort_sclk", {31'd0, SCLK}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_empty", {31'd0, data_empty}, 32'd1);
        step();
        step();
        reset = 1'b0;
        step();
        applyStimulus(32'h00ABCD5A, 8'd2);
        captureFrame(-1, '0, bits, low_cycles, rises, done_low, done_end, fall_cycle, timed_out);
        checkOutput("post_reset_timeout", {31'd0, timed_out}, 32'd0);
        checkOutput("post_reset_frame", {8'd0, bits}, {8'd0, expFrame(32'h00ABCD5A)});
        checkOutput("post_reset_len", low_cycles, 96);
        waitBusyLow(lag, timed_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
